// File: rtl/corelet_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : corelet_seq                                                   |
// | Purpose  : Self-sequencing weight-stationary corelet. An internal FSM    |
// |            loads a COL x ROW weight tile and streams N activation        |
// |            vectors through the MAC array. It then drains the psums from  |
// |            the output FIFO and accumulates them across K tiles. The      |
// |            accumulated vectors are presented on a valid/ready stream,    |
// |            with optional ReLU applied.                                   |
// | Ports    : clk, reset (async, active-low)                                |
// |            i_start/i_n_ktile/i_n_vec/i_relu_en/i_mode/i_data_mode        |
// |                     job configuration, sampled on a legal start in IDLE  |
// |            i_in_data/i_in_valid/o_in_ready                               |
// |                     weight words (LOAD) and activation vectors (EXEC)    |
// |            o_out_data/o_out_valid/i_out_ready                            |
// |                     accumulated output vectors                           |
// |            o_busy, o_done (1-cycle pulse), o_err (sticky config error)   |
// | i_mode=1 : weights are two's complement                                  |
// | i_data_mode=1 : activations are two's complement                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module corelet_seq #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int BW        = 4,
    parameter int PSUM_BW   = 16,
    parameter int VEC_MAX   = 16,
    parameter int KTILE_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [$clog2(KTILE_MAX):0] i_n_ktile,
    input  logic [$clog2(VEC_MAX):0]   i_n_vec,
    input  logic                       i_relu_en,
    input  logic                       i_mode,
    input  logic                       i_data_mode,
    input  logic [ROW*BW-1:0]          i_in_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [COL*PSUM_BW-1:0]     o_out_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int NKW = $clog2(KTILE_MAX) + 1;
    localparam int NVW = $clog2(VEC_MAX) + 1;
    localparam int VW  = (VEC_MAX > 1) ? $clog2(VEC_MAX) : 1;
    localparam int CLW = (COL > 1) ? $clog2(COL) : 1;
    localparam int CW  = $clog2(ROW + COL + VEC_MAX + 1) + 1;

    localparam logic [CW-1:0]  C_COL_LAST   = CW'(COL - 1);
    localparam logic [CW-1:0]  C_LWAIT_LAST = CW'(ROW + COL - 1);
    localparam logic [NVW-1:0] C_VEC_MAX    = NVW'(VEC_MAX);
    localparam logic [VW-1:0]  C_VLAST      = VW'(VEC_MAX - 1);
    localparam logic [CLW-1:0] C_CLAST      = CLW'(COL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_ACC   = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    // Reset: asserted asynchronously, released through two flops so every
    // downstream flop leaves reset on the same clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t                 r_state, w_next;
    logic [NKW-1:0]         r_nk, r_tile;
    logic [NVW-1:0]         r_nv;
    logic                   r_relu, r_mode, r_dmode, r_err, r_done;
    logic [CW-1:0]          r_cnt;
    logic                   w_cnt_inc;
    logic [ROW*BW-1:0]      r_l0_data;
    logic                   r_l0_ld, r_l0_ex;
    logic [ROW*BW-1:0]      r_w [COL];
    logic [CLW-1:0]         r_wcol;
    logic [COL*PSUM_BW-1:0] w_psum, r_mac_psum;
    logic                   r_mac_valid;
    logic [COL*PSUM_BW-1:0] r_fifo [VEC_MAX];
    logic [VW-1:0]          r_wp, r_rp;
    logic [NVW-1:0]         r_fcnt;
    logic [COL*PSUM_BW-1:0] r_acc [VEC_MAX];
    logic [COL*PSUM_BW-1:0] w_acc_next;
    logic [CW-1:0]          w_nv_m1;
    logic [NKW-1:0]         w_nk_m1;
    logic [VW-1:0]          w_vidx;
    logic                   w_cfg_ok, w_pop;

    assign w_cfg_ok = (i_n_ktile != '0) && (i_n_vec != '0) && (i_n_vec <= C_VEC_MAX);
    assign w_nv_m1  = CW'(r_nv) - CW'(1);
    assign w_nk_m1  = r_nk - NKW'(1);
    assign w_vidx   = r_cnt[VW-1:0];
    assign w_pop    = (r_state == S_ACC);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = (r_state != S_IDLE);
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_cfg_ok) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == C_COL_LAST) w_next = S_LWAIT;
                end
            end
            S_LWAIT: begin
                w_cnt_inc = 1'b1;
                if (r_cnt == C_LWAIT_LAST) w_next = S_EXEC;
            end
            S_EXEC: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == w_nv_m1) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_fcnt == r_nv) w_next = S_ACC;
            end
            S_ACC: begin
                w_cnt_inc = 1'b1;
                if (r_cnt == w_nv_m1) w_next = (r_tile < w_nk_m1) ? S_LOAD : S_OUT;
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == w_nv_m1) w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shared step counter: cleared on every state change, so each state
    // counts its own words / cycles / pops from zero.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_tile  <= '0;
            r_nk    <= '0;
            r_nv    <= '0;
            r_relu  <= 1'b0;
            r_mode  <= 1'b0;
            r_dmode <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_next != r_state) r_cnt <= '0;
            else if (w_cnt_inc)    r_cnt <= r_cnt + CW'(1);

            if (r_state == S_IDLE) r_tile <= '0;
            else if (r_state == S_ACC && w_next == S_LOAD) r_tile <= r_tile + NKW'(1);

            if (r_state == S_IDLE && i_start) begin
                if (w_cfg_ok) begin
                    r_nk    <= i_n_ktile;
                    r_nv    <= i_n_vec;
                    r_relu  <= i_relu_en;
                    r_mode  <= i_mode;
                    r_dmode <= i_data_mode;
                    r_err   <= 1'b0;
                end else begin
                    r_err   <= 1'b1;
                end
            end

            r_done <= (r_state == S_OUT) && i_out_ready && (r_cnt == w_nv_m1);
        end
    end

    // ---------------- l0 stage: registered write + strobes ----------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_l0_data <= '0;
            r_l0_ld   <= 1'b0;
            r_l0_ex   <= 1'b0;
        end else begin
            if (i_in_valid && o_in_ready) r_l0_data <= i_in_data;
            r_l0_ld <= i_in_valid && (r_state == S_LOAD);
            r_l0_ex <= i_in_valid && (r_state == S_EXEC);
        end
    end

    // ---------------- MAC array ----------------
    function automatic logic [PSUM_BW-1:0] ext(input logic [BW-1:0] x, input logic sgn);
        return {{(PSUM_BW-BW){sgn & x[BW-1]}}, x};
    endfunction

    // Weight word j holds column j's weights, one BW field per row.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)     r_wcol <= '0;
        else if (r_l0_ld) r_wcol <= (r_wcol == C_CLAST) ? '0 : r_wcol + CLW'(1);
    end

    always_ff @(posedge clk) begin
        if (r_l0_ld) r_w[r_wcol] <= r_l0_data;
    end

    // Lane c = sum over rows of act[r] * w[c][r], wrapping at PSUM_BW.
    always_comb begin
        logic [PSUM_BW-1:0] w_lane;
        w_psum = '0;
        for (int c = 0; c < COL; c++) begin
            w_lane = '0;
            for (int r = 0; r < ROW; r++) begin
                w_lane = w_lane + ext(r_l0_data[r*BW +: BW], r_dmode)
                                * ext(r_w[c][r*BW +: BW], r_mode);
            end
            w_psum[c*PSUM_BW +: PSUM_BW] = w_lane;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mac_psum  <= '0;
            r_mac_valid <= 1'b0;
        end else begin
            r_mac_valid <= r_l0_ex;
            if (r_l0_ex) r_mac_psum <= w_psum;
        end
    end

    // ---------------- ofifo ----------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (r_mac_valid) r_wp <= (r_wp == C_VLAST) ? '0 : r_wp + VW'(1);
            if (w_pop)       r_rp <= (r_rp == C_VLAST) ? '0 : r_rp + VW'(1);
            case ({r_mac_valid, w_pop})
                2'b10:   r_fcnt <= r_fcnt + NVW'(1);
                2'b01:   r_fcnt <= r_fcnt - NVW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_mac_valid) r_fifo[r_wp] <= r_mac_psum;
    end

    // ---------------- accumulator ----------------
    always_comb begin
        w_acc_next = '0;
        for (int c = 0; c < COL; c++) begin
            if (r_tile == '0)
                w_acc_next[c*PSUM_BW +: PSUM_BW] = r_fifo[r_rp][c*PSUM_BW +: PSUM_BW];
            else
                w_acc_next[c*PSUM_BW +: PSUM_BW] = r_acc[w_vidx][c*PSUM_BW +: PSUM_BW]
                                                 + r_fifo[r_rp][c*PSUM_BW +: PSUM_BW];
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_acc[w_vidx] <= w_acc_next;
    end

    // ---------------- output ----------------
    // Gated by OUT so the (unreset) accumulator never leaks onto the bus.
    always_comb begin
        o_out_data = '0;
        if (r_state == S_OUT) begin
            for (int c = 0; c < COL; c++) begin
                if (r_relu && r_acc[w_vidx][c*PSUM_BW + PSUM_BW - 1])
                    o_out_data[c*PSUM_BW +: PSUM_BW] = '0;
                else
                    o_out_data[c*PSUM_BW +: PSUM_BW] = r_acc[w_vidx][c*PSUM_BW +: PSUM_BW];
            end
        end
    end

    assign o_done = r_done;
    assign o_err  = r_err;

endmodule
`default_nettype wire

// File: doc/corelet_seq.md
Name: corelet_seq

Overview:
Parametrised, self-sequencing corelet. It wraps the existing l0, mac_array and ofifo submodules, sized by row/col/bw/psum_bw rather than fixed 128-bit buses. An internal FSM runs a K-tiled weight-stationary matmul: load weights, stream activations, drain psums, and accumulate across n_ktile tiles into an internal buffer. Optional ReLU is applied on the final tile. The host uses only start/done and valid/ready streams; it never drives load/execute/rd/wr strobes.

Parameters:
row, 8, MAC array rows (activation lanes)
col, 8, MAC array columns (output lanes)
bw, 4, activation/weight width (bits)
psum_bw, 16, psum and accumulator width (bits)
vec_max, 16, max activation vectors per tile (accumulator depth)
ktile_max, 16, max K tiles per job

Ports:
clk  in  1  clock, all logic posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle job start pulse, honoured only in IDLE
n_ktile  in  clog2(ktile_max)+1  tiles per job (1..ktile_max), sampled on start
n_vec  in  clog2(vec_max)+1  vectors per tile (1..vec_max), sampled on start
relu_en  in  1  apply ReLU to final outputs, sampled on start
mode  in  1  passed to mac_array, sampled on start
data_mode  in  1  passed to l0/mac_array, sampled on start
in_data  in  row*bw  weight word (LOAD) or activation vector (EXEC)
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  col*psum_bw  accumulated (optionally ReLU'd) output vector
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last output accepted
err  out  1  sticky; set on start with n_ktile==0, n_vec==0 or n_vec>vec_max; cleared by next legal start

Behaviour:
- Reset (async assert, sync deassert via 2-flop synchroniser): FSM IDLE; in_ready, out_valid, busy, done = 0; out_data = 0; err = 0; counters 0; accumulator contents don't-care. Submodules receive the inverted synchronised reset.
- Reset mid-job: aborts immediately; no done; no outputs after deassert.
- Transfer rule: a transfer occurs on valid && ready at posedge. in_ready is high only in LOAD (until col words taken) and EXEC (until n_vec vectors taken).
- FSM states:
  - IDLE: a legal start samples the config and goes to LOAD. An illegal start sets err and stays in IDLE.
  - LOAD: each accepted word is written into l0 (wr registered one cycle) and driven with inst load=1. After col words, go to LWAIT.
  - LWAIT: row+col cycles of load propagation, then EXEC.
  - EXEC: each accepted vector is written to l0 and driven with execute=1. After n_vec vectors, go to DRAIN.
  - DRAIN: wait until ofifo holds n_vec entries (ofifo wr = registered mac valid), then ACC.
  - ACC: pop one ofifo entry per cycle into acc[i]. Tile 0 does acc[i] = psum. Later tiles do acc[i] = acc[i] + psum, per lane, psum_bw wraparound, two's complement. After n_vec pops: if the tile counter < n_ktile-1, increment it and go to LOAD; else go to OUT.
  - OUT: present acc[i] for i = 0..n_vec-1 in order, each lane max(0, x) if relu_en. out_data holds stable while out_valid && !out_ready. After the last transfer, pulse done and go to IDLE.
- start while busy: ignored, no err.
- in_valid outside LOAD/EXEC: ignored, nothing consumed.
- Backpressure on in_valid: the FSM waits in LOAD/EXEC indefinitely, and l0/mac strobes are held low in idle cycles.
- ofifo is never read except in ACC and never overflows: n_vec <= vec_max <= ofifo depth.
- Fixed overhead per tile, with no input stalls: LOAD col + LWAIT row+col + EXEC n_vec + DRAIN (array latency) + ACC n_vec cycles.

Test Plan:
- Reset mid-EXEC: busy=1, reset low for 1 cycle -> busy, in_ready, out_valid = 0; no done; the next job runs normally.
- Single tile, default params: n_ktile=1, n_vec=1, all weights 1, activation all 2 -> one output, every lane 16 (8 rows x 1 x 2); done pulses one cycle after that transfer.
- K accumulation: n_ktile=3, n_vec=2, weights 1, activations 1 -> 2 outputs, each lane 24 (3 x 8).
- ReLU: weights -1 (signed mode), activations 3, relu_en=1 -> lanes 0; same job with relu_en=0 -> lanes -24 (16'hFFE8).
- Backpressure: out_ready toggled 1/0 each cycle, and in_valid deasserted randomly -> out_data stable while stalled; outputs in order and correct; in_ready never high outside LOAD/EXEC.
- Illegal config: start with n_vec=0 -> err=1, busy stays 0; start while busy -> ignored; next legal start -> err=0.
